// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/exec hazard inputs, memory hold, redirect request, stall/flush outputs.
// No storage; pure wiring between the pipeline and the hazard controller.
// master = pipeline side driving hazard inputs, slave = controller.
interface pipeline_hazard_ctrl_if;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_if;
    logic        stall_de;
    logic        stall_ex;
    logic        bubble_ex;
    logic        flush_de;
    logic        fe_redirect_valid;
    logic [31:0] fe_redirect_pc;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        output ex_valid, ex_is_load, ex_rd, mem_busy, redirect_valid, redirect_pc,
        input  stall_if, stall_de, stall_ex, bubble_ex, flush_de,
        input  fe_redirect_valid, fe_redirect_pc, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        input  ex_valid, ex_is_load, ex_rd, mem_busy, redirect_valid, redirect_pc,
        output stall_if, stall_de, stall_ex, bubble_ex, flush_de,
        output fe_redirect_valid, fe_redirect_pc, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stalls, memory holds, redirect flushes, perf counters.
// Latency: stalls/bubbles combinational in the detecting cycle; fetch redirect registered, valid one cycle after acceptance.
// Backpressure: mem_busy holds every stage combinationally in any state, including reset.
module pipeline_hazard_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_ctrl_if.slave        hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_LD_STALL = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  flush_left_q, flush_left_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        fe_vld_q, fe_vld_d;
    logic [31:0] fe_pc_q, fe_pc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic        load_use;
    logic        accept;
    logic [31:0] accept_pc;
    logic        stall_front;
    logic        bubble;
    logic        flush_de;
    logic        stall_de;

    // Gated with rst_n so the RUN-state hazard path stays quiet while reset is held.
    assign load_use = rst_n & hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) & hz.de_valid &
                      ((hz.de_use_rs1 & (hz.de_rs1 == hz.ex_rd)) |
                       (hz.de_use_rs2 & (hz.de_rs2 == hz.ex_rd)));

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        fe_vld_d     = 1'b0;
        fe_pc_d      = fe_pc_q;
        accept       = 1'b0;
        accept_pc    = hz.redirect_pc;
        stall_front  = 1'b0;
        bubble       = 1'b0;
        flush_de     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.redirect_valid) begin
                    accept = 1'b1;
                end else if (hz.mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (load_use) begin
                    stall_front = 1'b1;
                    bubble      = 1'b1;
                    state_d     = ST_LD_STALL;
                end
            end
            ST_LD_STALL: begin
                stall_front = 1'b1;
                bubble      = 1'b1;
                if (hz.redirect_valid) begin
                    accept = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_de = 1'b1;
                bubble   = 1'b1;
                if (hz.redirect_valid) begin
                    accept = 1'b1;
                end else if (flush_left_q <= 2'd1) begin
                    flush_left_d = 2'd0;
                    state_d      = ST_RUN;
                end else begin
                    flush_left_d = flush_left_q - 2'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_busy) begin
                    if (hz.redirect_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = hz.redirect_pc;
                    end
                end else if (hz.redirect_valid || pend_q) begin
                    // A redirect arriving on the release cycle is newer than the parked one.
                    accept    = 1'b1;
                    accept_pc = hz.redirect_valid ? hz.redirect_pc : pend_pc_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (accept) begin
            state_d      = ST_FLUSH;
            flush_left_d = 2'd2;
            fe_vld_d     = 1'b1;
            fe_pc_d      = accept_pc;
            pend_d       = 1'b0;
        end
    end

    assign stall_de = stall_front | hz.mem_busy;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_de && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (accept && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_left_q <= 2'd0;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'd0;
            fe_vld_q     <= 1'b0;
            fe_pc_q      <= 32'd0;
            stall_cnt_q  <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            fe_vld_q     <= fe_vld_d;
            fe_pc_q      <= fe_pc_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hz.stall_if          = stall_front | hz.mem_busy;
    assign hz.stall_de          = stall_de;
    assign hz.stall_ex          = hz.mem_busy;
    assign hz.bubble_ex         = bubble;
    assign hz.flush_de          = flush_de;
    assign hz.fe_redirect_valid = fe_vld_q;
    assign hz.fe_redirect_pc    = fe_pc_q;
    assign hz.state_o           = state_q;
    assign hz.stall_cnt         = stall_cnt_q;
    assign hz.flush_cnt         = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        de_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        exv;
        logic        exl;
        logic [4:0]  rd;
        logic        mb;
        logic        rv;
        logic [31:0] rpc;
    } stim_t;

    typedef struct packed {
        logic        sif;
        logic        sde;
        logic        sex;
        logic        bub;
        logic        fl;
        logic        fev;
        logic [31:0] fepc;
        logic [1:0]  st;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: remaining flush cycles, one-shot load-use stall, memory-wait flag, parked redirects.
    int          m_flush_left;
    bit          m_ld_stall;
    bit          m_mem_wait;
    logic [31:0] m_pend[$];
    bit          m_fe_v;
    logic [31:0] m_fe_pc;
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_ld_stall   = 0;
        m_mem_wait   = 0;
        m_pend.delete();
        m_fe_v       = 0;
        m_fe_pc      = 32'd0;
        m_scnt       = 32'd0;
        m_fcnt       = 32'd0;
    endtask

    task automatic step(input stim_t s);
        exp_t        e;
        bit          lu, acc, sf, bub, fl;
        logic [31:0] apc;
        @(posedge clk);
        #1;
        rst_n             = s.rst_n;
        hz.de_valid       = s.de_valid;
        hz.de_rs1         = s.rs1;
        hz.de_rs2         = s.rs2;
        hz.de_use_rs1     = s.u1;
        hz.de_use_rs2     = s.u2;
        hz.ex_valid       = s.exv;
        hz.ex_is_load     = s.exl;
        hz.ex_rd          = s.rd;
        hz.mem_busy       = s.mb;
        hz.redirect_valid = s.rv;
        hz.redirect_pc    = s.rpc;

        e = '0;
        if (!s.rst_n) begin
            model_reset();
            e.sif = s.mb;
            e.sde = s.mb;
            e.sex = s.mb;
        end else begin
            lu = s.exv && s.exl && (s.rd != 0) && s.de_valid &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
            acc = 0; apc = s.rpc; sf = 0; bub = 0; fl = 0;
            e.st   = (m_flush_left > 0) ? 2'd1 : m_mem_wait ? 2'd2 : m_ld_stall ? 2'd3 : 2'd0;
            e.fev  = m_fe_v;
            e.fepc = m_fe_pc;
            e.scnt = m_scnt;
            e.fcnt = m_fcnt;
            if (m_flush_left > 0) begin
                fl = 1; bub = 1;
                if (s.rv) acc = 1;
                else m_flush_left--;
            end else if (m_ld_stall) begin
                sf = 1; bub = 1;
                m_ld_stall = 0;
                if (s.rv) acc = 1;
            end else if (m_mem_wait) begin
                if (s.mb) begin
                    if (s.rv) begin
                        m_pend.delete();
                        m_pend.push_back(s.rpc);
                    end
                end else begin
                    m_mem_wait = 0;
                    if (s.rv) acc = 1;
                    else if (m_pend.size() != 0) begin
                        acc = 1;
                        apc = m_pend[$];
                    end
                end
            end else begin
                if (s.rv) acc = 1;
                else if (s.mb) m_mem_wait = 1;
                else if (lu) begin
                    sf = 1; bub = 1; m_ld_stall = 1;
                end
            end
            e.sif = sf | s.mb;
            e.sde = sf | s.mb;
            e.sex = s.mb;
            e.bub = bub;
            e.fl  = fl;
            m_fe_v = acc;
            if (acc) begin
                m_fe_pc      = apc;
                m_flush_left = 2;
                m_ld_stall   = 0;
                m_mem_wait   = 0;
                m_pend.delete();
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            end
            if ((sf || s.mb) && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stall_if",  hz.stall_if,          e.sif);
                chk("stall_de",  hz.stall_de,          e.sde);
                chk("stall_ex",  hz.stall_ex,          e.sex);
                chk("bubble_ex", hz.bubble_ex,         e.bub);
                chk("flush_de",  hz.flush_de,          e.fl);
                chk("fe_vld",    hz.fe_redirect_valid, e.fev);
                chk("fe_pc",     hz.fe_redirect_pc,    e.fepc);
                chk("state",     hz.state_o,           e.st);
                chk("stall_cnt", hz.stall_cnt,         e.scnt);
                chk("flush_cnt", hz.flush_cnt,         e.fcnt);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t ldu(input logic [4:0] r);
        stim_t s;
        s = idle();
        s.de_valid = 1'b1; s.rs2 = r; s.u2 = 1'b1;
        s.exv = 1'b1; s.exl = 1'b1; s.rd = r;
        return s;
    endfunction

    function automatic stim_t redir(input logic [31:0] pc);
        stim_t s;
        s = idle();
        s.rv = 1'b1; s.rpc = pc;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst_n    = ($urandom_range(0, 199) != 0);
        s.de_valid = ($urandom_range(0, 3) != 0);
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.u1       = ($urandom_range(0, 1) != 0);
        s.u2       = ($urandom_range(0, 1) != 0);
        s.exv      = ($urandom_range(0, 3) != 0);
        s.exl      = ($urandom_range(0, 1) != 0);
        s.rd       = 5'($urandom_range(0, 3));
        s.mb       = ($urandom_range(0, 6) == 0);
        s.rv       = ($urandom_range(0, 9) == 0);
        s.rpc      = $urandom;
        return s;
    endfunction

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        step(s);
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        hz.de_valid = 0; hz.de_rs1 = 0; hz.de_rs2 = 0; hz.de_use_rs1 = 0; hz.de_use_rs2 = 0;
        hz.ex_valid = 0; hz.ex_is_load = 0; hz.ex_rd = 0; hz.mem_busy = 0;
        hz.redirect_valid = 0; hz.redirect_pc = 0;
        model_reset();

        // Reset state, then mem_busy stalls propagating while reset is held.
        do_reset();
        s = idle(); s.rst_n = 1'b0; s.mb = 1'b1;
        step(s);
        #1 chk("rst_stall_if", hz.stall_if, 1);

        // Load into x0 never stalls.
        do_reset();
        s = ldu(5'd0);
        step(s);
        #1 chk("x0_no_stall", hz.stall_de, 0);
        step(idle());
        #1 chk("x0_state", hz.state_o, 0);

        // Load x5 consumed via rs2: two stall cycles.
        do_reset();
        step(ldu(5'd5));
        #1 chk("lu_bubble0", hz.bubble_ex, 1);
        step(ldu(5'd5));
        #1 chk("lu_state3", hz.state_o, 3);
        step(idle());
        #1 chk("lu_stall_cnt", hz.stall_cnt, 2);
        chk("lu_state0", hz.state_o, 0);

        // Redirect from RUN.
        do_reset();
        step(redir(32'h100));
        step(idle());
        #1 chk("rd_fe_vld", hz.fe_redirect_valid, 1);
        chk("rd_fe_pc", hz.fe_redirect_pc, 32'h100);
        chk("rd_flush1", hz.flush_de, 1);
        step(idle());
        #1 chk("rd_flush2", hz.flush_de, 1);
        chk("rd_fe_vld_drop", hz.fe_redirect_valid, 0);
        step(idle());
        #1 chk("rd_flush_end", hz.flush_de, 0);
        chk("rd_flush_cnt", hz.flush_cnt, 1);

        // Redirect parked during a 3-cycle memory hold.
        do_reset();
        s = idle(); s.mb = 1'b1;
        step(s);
        s.rv = 1'b1; s.rpc = 32'h40;
        step(s);
        #1 chk("mw_stall", hz.stall_if, 1);
        s.rv = 1'b0;
        step(s);
        step(idle());
        #1 chk("mw_release_state", hz.state_o, 2);
        step(idle());
        #1 chk("mw_flush_state", hz.state_o, 1);
        chk("mw_fe_pc", hz.fe_redirect_pc, 32'h40);

        // Redirect aborts LD_STALL, second redirect extends FLUSH.
        do_reset();
        step(ldu(5'd7));
        step(redir(32'h80));
        #1 chk("abort_stall_de", hz.stall_de, 1);
        step(redir(32'hC0));
        #1 chk("abort_no_stall", hz.stall_de, 0);
        step(idle());
        #1 chk("ext_fe_pc", hz.fe_redirect_pc, 32'hC0);
        step(idle());
        #1 chk("ext_state", hz.state_o, 1);
        step(idle());
        #1 chk("ext_flush_cnt", hz.flush_cnt, 2);

        // Reset in the first FLUSH cycle.
        do_reset();
        step(redir(32'h10));
        s = idle(); s.rst_n = 1'b0;
        step(s);
        #1 chk("rstf_flush", hz.flush_de, 0);
        chk("rstf_fe_vld", hz.fe_redirect_valid, 0);
        chk("rstf_fe_pc", hz.fe_redirect_pc, 0);
        step(idle());
        #1 chk("rstf_state", hz.state_o, 0);

        for (int i = 0; i < 3000; i++) begin
            step(rnd());
        end

        @(negedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock) and rst_n (in, 1, async reset, active low).
REQ-002 de_valid  in  1  decode stage holds a valid instruction.
REQ-003 de_rs1, de_rs2  in  5 each  decode source registers.
REQ-004 de_use_rs1, de_use_rs2  in  1 each  decode instruction reads that source.
REQ-005 ex_valid, ex_is_load  in  1 each  exec stage holds a valid instruction, which is a load.
REQ-006 ex_rd  in  5  exec destination register.
REQ-007 mem_busy  in  1  data memory not ready; the whole pipe must hold.
REQ-008 redirect_valid  in  1  exec requests a PC redirect (branch/jump taken).
REQ-009 redirect_pc  in  32  redirect target.
REQ-010 stall_if, stall_de, stall_ex  out  1 each  hold that stage's register.
REQ-011 bubble_ex  out  1  insert a NOP into exec instead of the decode output.
REQ-012 flush_de  out  1  kill the decode-stage contents.
REQ-013 fe_redirect_valid, fe_redirect_pc  out  1, 32  registered redirect to fetch.
REQ-014 state_o  out  2  FSM state: RUN=0, FLUSH=1, MEM_WAIT=2, LD_STALL=3.
REQ-015 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-016 load_use SHALL be defined as ex_valid & ex_is_load & ex_rd!=0 & de_valid & ((de_use_rs1 & de_rs1==ex_rd) | (de_use_rs2 & de_rs2==ex_rd)).
REQ-017 Event priority SHALL be: redirect_valid > mem_busy > load_use.
REQ-018 stall_if, stall_de and stall_ex SHALL be 1 combinationally in any cycle with mem_busy=1, in any state.
REQ-019 RUN: redirect_valid -> FLUSH; else mem_busy -> MEM_WAIT; else load_use -> LD_STALL; else stay in RUN.
REQ-020 RUN with load_use, no redirect and no mem_busy: stall_if=stall_de=bubble_ex=1 combinationally in that same cycle.
REQ-021 LD_STALL SHALL last exactly 1 cycle with stall_if=stall_de=bubble_ex=1, giving 2 bubbles per load-use, then return to RUN.
REQ-022 redirect_valid in LD_STALL SHALL abort the stall and go to FLUSH; the abort cycle still asserts the stall outputs.
REQ-023 On redirect acceptance: redirect_pc is latched into fe_redirect_pc; fe_redirect_valid=1 for exactly the following cycle; flush counter is loaded with 2; flush_cnt is incremented.
REQ-024 FLUSH SHALL assert flush_de=bubble_ex=1 for 2 cycles, then go to RUN.
REQ-025 redirect_valid in FLUSH SHALL be accepted again, per REQ-023, which restarts the 2-cycle count.
REQ-026 MEM_WAIT: redirect_valid SHALL set a pending flag and latch redirect_pc; a newer redirect overwrites the latched PC.
REQ-027 MEM_WAIT exit: in the first cycle with mem_busy=0, go to FLUSH if pending (accepted per REQ-023, pending cleared), else to RUN.
REQ-028 stall_cnt SHALL increment every cycle stall_de=1; flush_cnt SHALL increment per accepted redirect; both saturate at 0xFFFFFFFF.
REQ-029 Outputs not asserted by the rules above SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force: state RUN; all outputs 0; fe_redirect_pc=0; counters 0; pending and flush counter cleared.
REQ-031 Reset mid-FLUSH, MEM_WAIT or LD_STALL SHALL discard the operation, including any pending redirect.
REQ-032 mem_busy-driven stalls SHALL still propagate combinationally during reset.

Verification
REQ-033 Load x5 in exec, decode reads rs2=x5 -> 2 cycles of stall_de=bubble_ex=1, state 0->3->0, stall_cnt=2.
REQ-034 Load x0 in exec, decode reads x0 -> no stall, state stays 0.
REQ-035 redirect_valid with pc=0x100 in RUN -> next cycle fe_redirect_valid=1 and fe_redirect_pc=0x100; flush_de=1 for 2 cycles; flush_cnt=1.
REQ-036 mem_busy high 3 cycles with redirect 0x40 in its 2nd cycle -> stalls for 3 cycles, then FLUSH, fe_redirect_pc=0x40.
REQ-037 Redirect 0x80 during LD_STALL -> FLUSH next cycle, no further stall; second redirect 0xC0 in FLUSH -> flush extends 2 more cycles, flush_cnt=2.
REQ-038 rst_n low in 1st FLUSH cycle -> all outputs 0 immediately, state RUN after release.
